// File: rtl/census_linebuf.sv
// rtl/census_linebuf.sv - three-line buffer and registered 3x3 window for the census path
// Optional build macro: CENSUS_LINEBUF_EDGE_REPLICATE_EN (replicate column 0 across the window at line start)
module census_linebuf #(
  parameter int PIXEL_WIDTH     = 8,
  parameter int PIXEL_CNT_DEPTH = 3,
  parameter int LINE_CNT_WIDTH  = 4
) (
  input  logic                       pixelclock,
  input  logic                       reset,
  input  logic                       lineclock,
  input  logic                       pixel_valid,
  input  logic [PIXEL_WIDTH-1:0]     pixel_in,
  input  logic [PIXEL_CNT_DEPTH:0]   pixelcount,
  output logic [9*PIXEL_WIDTH-1:0]   window,
  output logic                       window_valid,
  output logic [LINE_CNT_WIDTH-1:0]  linecount
);

  localparam int LINE_WIDTH = 2 ** (PIXEL_CNT_DEPTH + 1);
  localparam int COL_W      = 3 * PIXEL_WIDTH;
  localparam logic [LINE_CNT_WIDTH-1:0] LINE_CNT_MAX = '1;
  localparam logic [LINE_CNT_WIDTH-1:0] TWO_LINES    = LINE_CNT_WIDTH'(2);

  logic [PIXEL_WIDTH-1:0] mem_a [LINE_WIDTH];
  logic [PIXEL_WIDTH-1:0] mem_b [LINE_WIDTH];

  logic [COL_W-1:0] col;
  logic [COL_W-1:0] col_d0;
  logic [COL_W-1:0] col_d1;
  logic [COL_W-1:0] col_d2;
  logic             lineclock_d;
  logic             line_end;
  logic             win_ok;

  // Column is {top, mid, bottom}: line-before-previous, previous line, current pixel.
  assign col      = {mem_b[pixelcount], mem_a[pixelcount], pixel_in};
  assign line_end = lineclock & ~lineclock_d;

`ifdef CENSUS_LINEBUF_EDGE_REPLICATE_EN
  always_comb begin
    win_ok = (linecount >= TWO_LINES);
  end
`else
  localparam logic [PIXEL_CNT_DEPTH:0] TWO_COLS = (PIXEL_CNT_DEPTH + 1)'(2);

  // The two left columns still carry the previous line's tail until column 2.
  always_comb begin
    win_ok = (linecount >= TWO_LINES) && (pixelcount >= TWO_COLS);
  end
`endif

  // Line memories are deliberately not reset; consumers ignore them until two lines complete.
  always_ff @(posedge pixelclock) begin
    if (pixel_valid) begin
      mem_b[pixelcount] <= mem_a[pixelcount];
      mem_a[pixelcount] <= pixel_in;
    end
  end

  always_ff @(posedge pixelclock or posedge reset) begin
    if (reset) begin
      col_d0 <= '0;
      col_d1 <= '0;
      col_d2 <= '0;
    end else if (pixel_valid) begin
`ifdef CENSUS_LINEBUF_EDGE_REPLICATE_EN
      if (pixelcount == '0) begin
        col_d2 <= col;
        col_d1 <= col;
        col_d0 <= col;
      end else begin
        col_d2 <= col_d1;
        col_d1 <= col_d0;
        col_d0 <= col;
      end
`else
      col_d2 <= col_d1;
      col_d1 <= col_d0;
      col_d0 <= col;
`endif
    end
  end

  always_ff @(posedge pixelclock or posedge reset) begin
    if (reset) begin
      lineclock_d  <= 1'b0;
      linecount    <= '0;
      window_valid <= 1'b0;
    end else begin
      lineclock_d  <= lineclock;
      window_valid <= pixel_valid && win_ok;
      if (line_end && (linecount != LINE_CNT_MAX)) begin
        linecount <= linecount + 1'b1;
      end
    end
  end

  // Row-major: each window row is {oldest column, middle, newest column}.
  for (genvar r = 0; r < 3; r++) begin : g_row
    assign window[(3-r)*COL_W-1 -: COL_W] = {col_d2[(2-r)*PIXEL_WIDTH +: PIXEL_WIDTH],
                                             col_d1[(2-r)*PIXEL_WIDTH +: PIXEL_WIDTH],
                                             col_d0[(2-r)*PIXEL_WIDTH +: PIXEL_WIDTH]};
  end

endmodule
